// File: rtl/serial2parallel_stream.sv
// -----------------------------------------------------------------------------
// serial2parallel_stream
//
// Serial-to-parallel converter. It takes a qualified serial bit input and
// delivers assembled words through a one-deep ready/valid holding register.
// Because the holding register is separate from the shift register, assembly
// of the next word continues while a finished word waits for downstream.
// A completed word that finds the holding register full and not draining is
// dropped, and the sticky overflow flag is raised.
//
// Parameters
//   WIDTH      word width in bits, 2..32
//   MSB_FIRST  0: the first accepted bit lands in word[0]
//              1: the first accepted bit lands in word[WIDTH-1]
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   start       resynchronise: drop the partial word and clear overflow
//   bit_valid   d carries a valid bit this cycle
//   d           serial data bit
//   word        assembled word, meaningful while word_valid=1
//   word_valid  holding register contains an undelivered word
//   word_ready  downstream accepts word this cycle
//   overflow    sticky: a completed word was dropped
//   busy        partial word in progress (bit_count != 0)
//   bit_count   bits accepted into the current partial word, 0..WIDTH-1
// -----------------------------------------------------------------------------
module serial2parallel_stream #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         bit_valid,
   input  logic                         d,
   output logic [WIDTH-1:0]             word,
   output logic                         word_valid,
   input  logic                         word_ready,
   output logic                         overflow,
   output logic                         busy,
   output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

   localparam int             CW         = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST_COUNT = CW'(WIDTH - 1);

   // Assembly state
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    count_q, count_d;
   logic             busy_q,  busy_d;

   // Holding register and flags
   logic [WIDTH-1:0] word_q,       word_d;
   logic             word_valid_q, word_valid_d;
   logic             overflow_q,   overflow_d;

   // Per-edge events
   logic [WIDTH-1:0] shifted;    // shift register with d taken in
   logic             complete;   // this edge accepts the WIDTH-th bit
   logic             drain;      // downstream takes the held word

   // Insert one bit according to the configured bit order. After WIDTH
   // insertions the first bit has travelled to word[0] (LSB-first) or to
   // word[WIDTH-1] (MSB-first).
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic              b);
      logic [WIDTH-1:0] nxt;
      if (MSB_FIRST) begin
         nxt = {cur[WIDTH-2:0], b};
      end else begin
         nxt = {b, cur[WIDTH-1:1]};
      end
      return nxt;
   endfunction

   // ---------------------------------------------------------------------------
   // Shift register and bit counter
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      shift_d  = shift_q;
      count_d  = count_q;
      complete = 1'b0;
      shifted  = shift_in(shift_q, d);

      if (start) begin
         // Resync wins over completion: the partial word is thrown away and,
         // if a bit arrives on the same edge, it becomes bit 1 of a new word.
         shift_d = '0;
         count_d = '0;
         if (bit_valid) begin
            shift_d = shift_in('0, d);
            count_d = CW'(1);
         end
      end else if (bit_valid) begin
         shift_d = shifted;
         if (count_q == LAST_COUNT) begin
            complete = 1'b1;
            count_d  = '0;
         end else begin
            count_d = count_q + CW'(1);
         end
      end
   end

   assign busy_d = (count_d != '0);

   // ---------------------------------------------------------------------------
   // Holding register, handshake and overflow
   // ---------------------------------------------------------------------------
   assign drain = word_valid_q & word_ready;

   always_comb begin
      word_d       = word_q;
      word_valid_d = word_valid_q;
      overflow_d   = overflow_q;

      if (complete) begin
         // The slot is free if empty or emptied on this very edge; in the
         // latter case word_valid simply stays high with the new word.
         if (!word_valid_q || word_ready) begin
            word_d       = shifted;
            word_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (drain) begin
         word_valid_d = 1'b0;
      end

      // start never coincides with complete, so clearing here cannot mask a
      // drop on the same edge.
      if (start) begin
         overflow_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: the held word is reset to zero together with its valid flag; it is
   // a single register, not a storage array, so the reset costs nothing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q      <= '0;
         count_q      <= '0;
         busy_q       <= 1'b0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, independent of statement order.
         shift_q      <= shift_d;
         count_q      <= count_d;
         busy_q       <= busy_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         overflow_q   <= overflow_d;
      end
   end

   assign word       = word_q;
   assign word_valid = word_valid_q;
   assign overflow   = overflow_q;
   assign busy       = busy_q;
   assign bit_count  = count_q;

endmodule

// File: tb/tb_serial2parallel_stream.sv
// -----------------------------------------------------------------------------
// tb_serial2parallel_stream
//
// Drives one LSB-first and one MSB-first instance from the same inputs and
// compares both against a reference model that keeps the accepted bits of the
// current partial word in a queue and packs them into a word on completion.
// -----------------------------------------------------------------------------
module tb_serial2parallel_stream;

   localparam int WIDTH = 8;
   localparam int CW    = $clog2(WIDTH + 1);

   logic clk = 1'b0;
   logic reset, start, bit_valid, d, word_ready;

   logic [WIDTH-1:0] word_l, word_m;
   logic             wv_l, wv_m, ovf_l, ovf_m, busy_l, busy_m;
   logic [CW-1:0]    cnt_l, cnt_m;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   serial2parallel_stream #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid), .d(d),
      .word(word_l), .word_valid(wv_l), .word_ready(word_ready),
      .overflow(ovf_l), .busy(busy_l), .bit_count(cnt_l)
   );

   serial2parallel_stream #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid), .d(d),
      .word(word_m), .word_valid(wv_m), .word_ready(word_ready),
      .overflow(ovf_m), .busy(busy_m), .bit_count(cnt_m)
   );

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   bit               m_bits[$];   // accepted bits of the partial word, in order
   bit               m_hv;        // holding register occupied
   bit               m_ovf;
   logic [WIDTH-1:0] m_word_l, m_word_m;

   function automatic logic [WIDTH-1:0] pack_bits(input bit msb_first);
      logic [WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < m_bits.size(); i++) begin
         if (msb_first) w[WIDTH-1-i] = m_bits[i];
         else           w[i]         = m_bits[i];
      end
      return w;
   endfunction

   task automatic model_clear();
      m_bits.delete();
      m_hv     = 1'b0;
      m_ovf    = 1'b0;
      m_word_l = '0;
      m_word_m = '0;
   endtask

   task automatic model_tick();
      bit               done;
      logic [WIDTH-1:0] nl, nm;
      done = 1'b0;
      nl   = '0;
      nm   = '0;
      if (start) begin
         m_bits.delete();
         if (bit_valid) m_bits.push_back(d);
      end else if (bit_valid) begin
         m_bits.push_back(d);
         if (m_bits.size() == WIDTH) begin
            done = 1'b1;
            nl   = pack_bits(1'b0);
            nm   = pack_bits(1'b1);
            m_bits.delete();
         end
      end
      if (done) begin
         if (!m_hv || word_ready) begin
            m_hv     = 1'b1;
            m_word_l = nl;
            m_word_m = nm;
         end else begin
            m_ovf = 1'b1;
         end
      end else if (m_hv && word_ready) begin
         m_hv = 1'b0;
      end
      if (start) m_ovf = 1'b0;
   endtask

   // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
   task automatic step(input logic s, input logic bv, input logic dd, input logic rdy);
      start      = s;
      bit_valid  = bv;
      d          = dd;
      word_ready = rdy;
      model_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      start      = 1'b0;
      bit_valid  = 1'b0;
      d          = 1'b0;
      word_ready = 1'b0;
      reset      = 1'b1;
      model_clear();
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      apply_reset();
      tests_run++;
      if ({word_l, wv_l, ovf_l, busy_l, cnt_l} !== '0) begin
         tests_failed++;
         $display("FAIL reset_lsb: got word=%h v=%b ovf=%b busy=%b cnt=%0d expected all 0",
                  word_l, wv_l, ovf_l, busy_l, cnt_l);
      end
      tests_run++;
      if ({word_m, wv_m, ovf_m, busy_m, cnt_m} !== '0) begin
         tests_failed++;
         $display("FAIL reset_msb: got word=%h v=%b ovf=%b busy=%b cnt=%0d expected all 0",
                  word_m, wv_m, ovf_m, busy_m, cnt_m);
      end
      release_reset();
   endtask

   task automatic test_back_to_back();
      logic [7:0] stream;
      stream = 8'h4D;
      apply_reset();
      release_reset();
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, stream[i], 1'b1);
            if (i == 6) begin
               tests_run++;
               if (wv_l !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL b2b_early_valid: got %b expected 0", wv_l);
               end
            end
            if (w == 1 && i == 0) begin
               tests_run++;
               if (wv_l !== 1'b0 || cnt_l !== CW'(1)) begin
                  tests_failed++;
                  $display("FAIL b2b_one_cycle: got valid=%b cnt=%0d expected valid=0 cnt=1",
                           wv_l, cnt_l);
               end
            end
         end
         tests_run++;
         if (wv_l !== 1'b1 || word_l !== 8'h4D) begin
            tests_failed++;
            $display("FAIL b2b_lsb_word: got valid=%b word=%h expected valid=1 word=4d", wv_l, word_l);
         end
         tests_run++;
         if (wv_m !== 1'b1 || word_m !== 8'hB2) begin
            tests_failed++;
            $display("FAIL b2b_msb_word: got valid=%b word=%h expected valid=1 word=b2", wv_m, word_m);
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (wv_l !== 1'b0 || wv_m !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_drain: got valid=%b/%b expected 0/0", wv_l, wv_m);
      end
   endtask

   task automatic test_gapped();
      logic [7:0] stream;
      stream = 8'h4D;
      apply_reset();
      release_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, ~stream[i], 1'b1);
         tests_run++;
         if (cnt_l !== CW'(i)) begin
            tests_failed++;
            $display("FAIL gap_idle_count: got %0d expected %0d", cnt_l, i);
         end
         step(1'b0, 1'b1, stream[i], 1'b1);
         tests_run++;
         if (cnt_l !== CW'((i + 1) % 8)) begin
            tests_failed++;
            $display("FAIL gap_valid_count: got %0d expected %0d", cnt_l, (i + 1) % 8);
         end
      end
      tests_run++;
      if (wv_l !== 1'b1 || word_l !== 8'h4D || word_m !== 8'hB2) begin
         tests_failed++;
         $display("FAIL gap_word: got valid=%b lsb=%h msb=%h expected 1 4d b2", wv_l, word_l, word_m);
      end
   endtask

   task automatic test_backpressure_overflow();
      logic [7:0] stream;
      stream = 8'h4D;
      apply_reset();
      release_reset();
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, stream[i], 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
      tests_run++;
      if (wv_l !== 1'b1 || word_l !== 8'h4D || word_m !== 8'hB2 || ovf_l !== 1'b1 || ovf_m !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_overflow: got valid=%b lsb=%h msb=%h ovf=%b/%b expected 1 4d b2 1/1",
                  wv_l, word_l, word_m, ovf_l, ovf_m);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (wv_l !== 1'b0 || ovf_l !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_drain_sticky: got valid=%b ovf=%b expected valid=0 ovf=1", wv_l, ovf_l);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (ovf_l !== 1'b0 || ovf_m !== 1'b0 || cnt_l !== '0) begin
         tests_failed++;
         $display("FAIL bp_start_clears: got ovf=%b/%b cnt=%0d expected 0/0 0", ovf_l, ovf_m, cnt_l);
      end
   endtask

   task automatic test_resync();
      logic [7:0] stream;
      stream = 8'h4D;
      apply_reset();
      release_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b1);
      step(1'b1, 1'b1, stream[0], 1'b1);
      tests_run++;
      if (cnt_l !== CW'(1) || busy_l !== 1'b1 || busy_m !== 1'b1) begin
         tests_failed++;
         $display("FAIL resync_start: got cnt=%0d busy=%b/%b expected 1 1/1", cnt_l, busy_l, busy_m);
      end
      for (int i = 1; i < 8; i++) begin
         step(1'b0, 1'b1, stream[i], 1'b1);
         tests_run++;
         if (busy_l !== (i != 7)) begin
            tests_failed++;
            $display("FAIL resync_busy: bit %0d got %b expected %b", i, busy_l, (i != 7));
         end
      end
      tests_run++;
      if (wv_l !== 1'b1 || word_l !== 8'h4D || word_m !== 8'hB2) begin
         tests_failed++;
         $display("FAIL resync_word: got valid=%b lsb=%h msb=%h expected 1 4d b2", wv_l, word_l, word_m);
      end
   endtask

   task automatic test_drain_and_complete();
      logic [7:0] first, second;
      first  = 8'h4D;
      second = 8'h0F;
      apply_reset();
      release_reset();
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, first[i], 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, second[i], (i == 7));
      tests_run++;
      if (wv_l !== 1'b1 || word_l !== 8'h0F || word_m !== 8'hF0 || ovf_l !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_complete: got valid=%b lsb=%h msb=%h ovf=%b expected 1 0f f0 0",
                  wv_l, word_l, word_m, ovf_l);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      release_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b1);
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      tests_run++;
      if ({word_l, wv_l, ovf_l, busy_l, cnt_l, word_m, wv_m, ovf_m, busy_m, cnt_m} !== '0) begin
         tests_failed++;
         $display("FAIL midreset_partial: got busy=%b cnt=%0d expected 0 0", busy_l, cnt_l);
      end
      release_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0);
         if (i == 6) begin
            tests_run++;
            if (wv_l !== 1'b0 || cnt_l !== CW'(7)) begin
               tests_failed++;
               $display("FAIL midreset_fresh7: got valid=%b cnt=%0d expected 0 7", wv_l, cnt_l);
            end
         end
      end
      tests_run++;
      if (wv_l !== 1'b1 || word_l !== m_word_l || word_m !== m_word_m) begin
         tests_failed++;
         $display("FAIL midreset_fresh8: got valid=%b lsb=%h msb=%h expected 1 %h %h",
                  wv_l, word_l, word_m, m_word_l, m_word_m);
      end
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      tests_run++;
      if ({word_l, wv_l, ovf_l, busy_l, cnt_l, word_m, wv_m, ovf_m, busy_m, cnt_m} !== '0) begin
         tests_failed++;
         $display("FAIL midreset_held: got valid=%b word=%h expected 0 00", wv_l, word_l);
      end
      release_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (wv_l !== 1'b0 || wv_m !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_no_pulse: got valid=%b/%b expected 0/0", wv_l, wv_m);
      end
   endtask

   task automatic test_random();
      logic [CW-1:0] exp_cnt;
      apply_reset();
      release_reset();
      for (int c = 0; c < 800; c++) begin
         step(1'($urandom_range(99) < 4), 1'($urandom_range(99) < 75),
              1'($urandom_range(1)), 1'($urandom_range(99) < 40));
         exp_cnt = CW'(m_bits.size());
         tests_run++;
         if ({wv_l, ovf_l, busy_l, cnt_l} !== {m_hv, m_ovf, (exp_cnt != '0), exp_cnt} ||
             {wv_m, ovf_m, busy_m, cnt_m} !== {m_hv, m_ovf, (exp_cnt != '0), exp_cnt}) begin
            tests_failed++;
            $display("FAIL rand_ctrl c=%0d: got v=%b/%b ovf=%b/%b cnt=%0d/%0d expected v=%b ovf=%b cnt=%0d",
                     c, wv_l, wv_m, ovf_l, ovf_m, cnt_l, cnt_m, m_hv, m_ovf, exp_cnt);
         end
         if (m_hv) begin
            tests_run++;
            if (word_l !== m_word_l || word_m !== m_word_m) begin
               tests_failed++;
               $display("FAIL rand_word c=%0d: got %h/%h expected %h/%h",
                        c, word_l, word_m, m_word_l, m_word_m);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gapped();
      test_backpressure_overflow();
      test_resync();
      test_drain_and_complete();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/serial2parallel_stream.md
# serial2parallel_stream

Parametrised serial-to-parallel converter with a qualified bit input, a buffered ready/valid word output, overflow detection and selectable bit order. It sits between a serial receive front end and word-oriented downstream logic. It replaces the fixed 8-bit converter wherever backpressure, gapped input or a different word width is needed.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 0, bit order.
  - 0: the first accepted bit lands in word[0].
  - 1: the first accepted bit lands in word[WIDTH-1].

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  resynchronise: discard the partial word and begin a new one.
- bit_valid  in  1  d carries a valid bit this cycle.
- d  in  1  serial data bit.
- word  out  WIDTH  assembled word; meaningful only while word_valid=1.
- word_valid  out  1  holding register contains an undelivered word.
- word_ready  in  1  downstream accepts word this cycle.
- overflow  out  1  sticky: a completed word was dropped.
- busy  out  1  partial word in progress (bit_count != 0).
- bit_count  out  clog2(WIDTH+1)  bits accepted into the current partial word, 0..WIDTH-1.

## Operation
- Datapath: shift register, bit counter and output holding register. The holding register is a one-deep buffer, separate from the shift register, so assembly continues while a word waits.
- A bit is accepted on an edge where bit_valid=1.
  - MSB_FIRST=0: shift right, d enters the MSB.
  - MSB_FIRST=1: shift left, d enters the LSB.
  - bit_count increments.
- Completion: the edge that accepts the WIDTH-th bit.
  - The full word, including this bit, is offered to the holding register.
  - bit_count returns to 0 on the same edge.
- Holding register loads the completed word when it is empty, or when it drains on the same edge (word_valid=1 and word_ready=1). In that case word_valid stays 1 and word changes to the new value.
- If the holding register is full and not draining on the completion edge:
  - the new word is dropped;
  - the held word is unchanged;
  - overflow is set to 1.
- Drain: word_valid=1 and word_ready=1 with no load on that edge → word_valid clears to 0.
- word is held stable while word_valid=1 and word_ready=0.
- start=1 on an edge:
  - discards the partial word and clears overflow;
  - start takes priority over completion: a bit that would have completed a word is not completed;
  - if bit_valid=1, d is accepted as bit 1 of the new word (bit_count=1);
  - if bit_valid=0, bit_count=0;
  - the holding register and its handshake are unaffected.
- overflow clears only on reset or start.
- bit_valid=0 with start=0: shift register and bit_count hold.

## Timing
- Reset values (asynchronous, immediate): word=0, word_valid=0, overflow=0, busy=0, bit_count=0, shift register=0.
- Latency: word_valid rises the cycle after the edge that accepts the WIDTH-th bit.
- Throughput: one word per WIDTH valid bits with no bubbles, provided word_ready is high at least once per WIDTH cycles.
- word_ready is ignored while word_valid=0.
- Reset asserted mid-word or mid-handshake:
  - all state is cleared;
  - the partial word and the held word are lost;
  - no word_valid pulse occurs after reset deasserts until WIDTH new bits are accepted.
- bit_count and busy are registered outputs; they update on the same edge as the shift.

## Test plan
- Back-to-back word, LSB-first:
  - Setup: WIDTH=8, MSB_FIRST=0, word_ready=1.
  - Stimulus: after reset, bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles.
  - Required: word=0x4D with word_valid=1 for exactly one cycle, starting the cycle after the 8th bit.
  - Repeat with MSB_FIRST=1 and the same stream → word=0xB2.
- Gapped input: same stream with bit_valid low on alternate cycles → word=0x4D, and bit_count walks 0..7 only on valid cycles.
- Backpressure and overflow:
  - Stimulus: word_ready=0; word 0x4D, then 8 bits forming 0xFF.
  - Required: word stays 0x4D with word_valid=1, overflow=1.
  - Then raise word_ready for 1 cycle → word_valid=0, overflow still 1.
  - Then pulse start → overflow=0.
- Resync:
  - Stimulus: 3 bits of garbage, then start=1 with bit_valid=1, d=1, followed by 7 bits 0,1,1,0,0,1,0.
  - Required: word=0x4D; busy=1 from the start edge until completion.
- Simultaneous drain and completion: word_valid=1 (0x4D) and word_ready=1 on the edge completing 0x0F → next cycle word=0x0F, word_valid=1, overflow=0.
- Reset mid-operation:
  - Stimulus: assert reset after 5 bits, and separately while word_valid=1.
  - Required: all outputs are 0 immediately after reset asserts; the next word requires 8 fresh bits.
